// File: rtl/id_ctrl_stage_if.sv
// Decode-stage bus: fetch handshake, EX handshake, flush and the registered decode outputs.
// master drives the stage inputs; slave is the id_ctrl_stage side.
interface id_ctrl_stage_if #(
  parameter int unsigned ALUOP_W   = 4,
  parameter int unsigned ILL_CNT_W = 8
);
  logic                 if_valid;
  logic [31:0]          instr;
  logic                 id_ready;
  logic                 ex_ready;
  logic                 flush;
  logic                 ex_valid;
  logic                 alusrc;
  logic                 regwrite;
  logic                 memwrite;
  logic                 memread;
  logic                 branch;
  logic                 jump;
  logic [ALUOP_W-1:0]   aluop;
  logic [2:0]           funct3_q;
  logic [4:0]           rd_q;
  logic [4:0]           rs1_q;
  logic [4:0]           rs2_q;
  logic                 illegal;
  logic [ILL_CNT_W-1:0] ill_cnt;

  modport master (
    output if_valid, instr, ex_ready, flush,
    input  id_ready, ex_valid, alusrc, regwrite, memwrite, memread, branch, jump, aluop,
           funct3_q, rd_q, rs1_q, rs2_q, illegal, ill_cnt
  );

  modport slave (
    input  if_valid, instr, ex_ready, flush,
    output id_ready, ex_valid, alusrc, regwrite, memwrite, memread, branch, jump, aluop,
           funct3_q, rd_q, rs1_q, rs2_q, illegal, ill_cnt
  );
endinterface

// File: rtl/id_ctrl_stage.sv
// RV32I decode stage: registered controls/fields, load-use stall and illegal detection.
// Define ID_CTRL_ILLCNT_EN to build the saturating illegal-instruction counter (else ill_cnt = 0).
module id_ctrl_stage #(
  parameter int unsigned ALUOP_W          = 4,
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned ILL_CNT_W        = 8
) (
  input logic            clk,
  input logic            rst_n,
  id_ctrl_stage_if.slave bus
);
  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcI      = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] F7Zero    = 7'b0000000;
  localparam logic [6:0] F7Alt     = 7'b0100000;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluAnd  = 4'd2;
  localparam logic [3:0] AluOr   = 4'd3;
  localparam logic [3:0] AluXor  = 4'd4;
  localparam logic [3:0] AluSll  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluSlt  = 4'd8;
  localparam logic [3:0] AluSltu = 4'd9;

  localparam int unsigned CntW = 3;

  typedef enum logic [0:0] {StRun, StStall} state_e;

  typedef struct packed {
    logic       alusrc;
    logic       regwrite;
    logic       memwrite;
    logic       memread;
    logic       branch;
    logic       jump;
    logic       illegal;
    logic [3:0] aluop;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } payload_t;

  state_e          state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            ex_valid_d, ex_valid_q;
  payload_t        pay_d, pay_q;
  payload_t        dec;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [3:0]      alu_f3op;
  logic            uses_rs1, uses_rs2, hazard, id_ready, accept;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];

  // Base operation selected by funct3 for the funct7 == 0 register and immediate forms.
  always_comb begin
    unique case (funct3)
      3'd0: alu_f3op = AluAdd;
      3'd1: alu_f3op = AluSll;
      3'd2: alu_f3op = AluSlt;
      3'd3: alu_f3op = AluSltu;
      3'd4: alu_f3op = AluXor;
      3'd5: alu_f3op = AluSrl;
      3'd6: alu_f3op = AluOr;
      3'd7: alu_f3op = AluAnd;
    endcase
  end

  always_comb begin
    dec        = '0;
    dec.aluop  = AluAdd;
    dec.funct3 = funct3;
    dec.rd     = bus.instr[11:7];
    dec.rs1    = bus.instr[19:15];
    dec.rs2    = bus.instr[24:20];
    case (opcode)
      OpcR: begin
        dec.regwrite = 1'b1;
        if (funct7 == F7Zero)                      dec.aluop   = alu_f3op;
        else if (funct7 == F7Alt && funct3 == 3'd0) dec.aluop   = AluSub;
        else if (funct7 == F7Alt && funct3 == 3'd5) dec.aluop   = AluSra;
        else                                        dec.illegal = 1'b1;
      end
      OpcI: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = alu_f3op;
        if (funct3 == 3'd1 && funct7 != F7Zero) dec.illegal = 1'b1;
        if (funct3 == 3'd5) begin
          if (funct7 == F7Alt)       dec.aluop   = AluSra;
          else if (funct7 != F7Zero) dec.illegal = 1'b1;
        end
      end
      OpcLoad: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.memread  = 1'b1;
        dec.illegal  = (funct3 != 3'b010);
      end
      OpcStore: begin
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
        dec.illegal  = (funct3 != 3'b010);
      end
      OpcBranch: begin
        dec.branch = 1'b1;
        if (funct3[2:1] == 2'b01) dec.illegal = 1'b1;
        else if (!funct3[2])      dec.aluop   = AluSub;
        else if (!funct3[1])      dec.aluop   = AluSlt;
        else                      dec.aluop   = AluSltu;
      end
      OpcJal: begin
        dec.jump     = 1'b1;
        dec.regwrite = 1'b1;
      end
      OpcJalr: begin
        dec.jump     = 1'b1;
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.illegal  = (funct3 != 3'b000);
      end
      OpcLui, OpcAuipc: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // An illegal word travels down the pipe with no side-effecting controls.
    if (dec.illegal) begin
      dec.alusrc   = 1'b0;
      dec.regwrite = 1'b0;
      dec.memwrite = 1'b0;
      dec.memread  = 1'b0;
      dec.branch   = 1'b0;
      dec.jump     = 1'b0;
      dec.aluop    = AluAdd;
    end
  end

  assign uses_rs1 = !(opcode inside {OpcLui, OpcAuipc, OpcJal});
  assign uses_rs2 = opcode inside {OpcR, OpcStore, OpcBranch};
  assign hazard   = ex_valid_q && pay_q.memread && (pay_q.rd != 5'd0) && bus.if_valid &&
                    ((uses_rs1 && dec.rs1 == pay_q.rd) || (uses_rs2 && dec.rs2 == pay_q.rd));
  assign id_ready = (!ex_valid_q || bus.ex_ready) && (state_q == StRun) && !hazard && !bus.flush;
  assign accept   = bus.if_valid && id_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ex_valid_d = ex_valid_q;
    pay_d      = pay_q;
    if (bus.flush) begin
      ex_valid_d = 1'b0;
      state_d    = StRun;
      cnt_d      = '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (accept) begin
            ex_valid_d = 1'b1;
            pay_d      = dec;
          end else if (bus.ex_ready) begin
            // Covers both a plain drain and the load-use bubble.
            ex_valid_d = 1'b0;
            if (hazard && LOAD_USE_BUBBLES > 1) begin
              state_d = StStall;
              cnt_d   = CntW'(LOAD_USE_BUBBLES - 1);
            end
          end
        end
        StStall: begin
          ex_valid_d = 1'b0;
          if (cnt_q <= CntW'(1)) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      cnt_q      <= '0;
      ex_valid_q <= 1'b0;
      pay_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ex_valid_q <= ex_valid_d;
      pay_q      <= pay_d;
    end
  end

`ifdef ID_CTRL_ILLCNT_EN
  logic [ILL_CNT_W-1:0] ill_cnt_d, ill_cnt_q;

  always_comb begin
    ill_cnt_d = ill_cnt_q;
    if (accept && dec.illegal && ill_cnt_q != '1) ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ill_cnt_q <= '0;
    else        ill_cnt_q <= ill_cnt_d;
  end

  assign bus.ill_cnt = ill_cnt_q;
`else
  assign bus.ill_cnt = '0;
`endif

  assign bus.id_ready = id_ready;
  assign bus.ex_valid = ex_valid_q;
  assign bus.alusrc   = pay_q.alusrc;
  assign bus.regwrite = pay_q.regwrite;
  assign bus.memwrite = pay_q.memwrite;
  assign bus.memread  = pay_q.memread;
  assign bus.branch   = pay_q.branch;
  assign bus.jump     = pay_q.jump;
  assign bus.aluop    = ALUOP_W'(pay_q.aluop);
  assign bus.funct3_q = pay_q.funct3;
  assign bus.rd_q     = pay_q.rd;
  assign bus.rs1_q    = pay_q.rs1;
  assign bus.rs2_q    = pay_q.rs2;
  assign bus.illegal  = pay_q.illegal;
endmodule

// File: tb/tb_id_ctrl_stage.sv
// Bench for id_ctrl_stage: directed scenarios plus randomized traffic against a behavioural model.
// ill_cnt expectations follow ID_CTRL_ILLCNT_EN when the bench is built with it.
module tb_id_ctrl_stage;
  localparam int unsigned ALUOP_W   = 4;
  localparam int unsigned BUBBLES   = 2;
  localparam int unsigned ILL_CNT_W = 8;
  localparam int          IllMax    = (1 << ILL_CNT_W) - 1;
`ifdef ID_CTRL_ILLCNT_EN
  localparam bit IllEn = 1'b1;
`else
  localparam bit IllEn = 1'b0;
`endif

  localparam logic [31:0] AddX3  = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] LwX5   = 32'h0000A283;  // lw  x5,0(x1)
  localparam logic [31:0] AddX6  = 32'h00228333;  // add x6,x5,x2
  localparam logic [31:0] SubX7  = 32'h402083B3;  // sub x7,x1,x2
  localparam logic [31:0] AllOne = 32'hFFFFFFFF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ctrl_stage_if #(.ALUOP_W(ALUOP_W), .ILL_CNT_W(ILL_CNT_W)) bus ();

  id_ctrl_stage #(
    .ALUOP_W         (ALUOP_W),
    .LOAD_USE_BUBBLES(BUBBLES),
    .ILL_CNT_W       (ILL_CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit alusrc, regwrite, memwrite, memread, branch, jump, illegal;
    int aluop, f3, rd, rs1, rs2;
  } dec_t;

  int   checks   = 0;
  int   failures = 0;
  bit   m_valid;
  dec_t m;
  int   m_stall;
  int   m_ill;
  int   alu_by_f3 [8] = '{0, 5, 8, 9, 4, 6, 3, 2};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction meaning from the ISA tables, as plain integers.
  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    int op = int'(w[6:0]);
    int f3 = int'(w[14:12]);
    int f7 = int'(w[31:25]);
    d.alusrc = 0; d.regwrite = 0; d.memwrite = 0; d.memread = 0;
    d.branch = 0; d.jump = 0; d.illegal = 0; d.aluop = 0;
    d.f3 = f3; d.rd = int'(w[11:7]); d.rs1 = int'(w[19:15]); d.rs2 = int'(w[24:20]);
    case (op)
      'h33: begin
        d.regwrite = 1;
        if (f7 == 0) d.aluop = alu_by_f3[f3];
        else if (f7 == 'h20 && f3 == 0) d.aluop = 1;
        else if (f7 == 'h20 && f3 == 5) d.aluop = 7;
        else d.illegal = 1;
      end
      'h13: begin
        d.alusrc = 1; d.regwrite = 1; d.aluop = alu_by_f3[f3];
        if (f3 == 1 && f7 != 0) d.illegal = 1;
        if (f3 == 5 && f7 == 'h20) d.aluop = 7;
        else if (f3 == 5 && f7 != 0) d.illegal = 1;
      end
      'h03: begin d.alusrc = 1; d.regwrite = 1; d.memread = 1; d.illegal = (f3 != 2); end
      'h23: begin d.alusrc = 1; d.memwrite = 1; d.illegal = (f3 != 2); end
      'h63: begin
        d.branch  = 1;
        d.illegal = (f3 == 2 || f3 == 3);
        d.aluop   = (f3 < 2) ? 1 : (f3 < 6) ? 8 : 9;
      end
      'h6f: begin d.jump = 1; d.regwrite = 1; end
      'h67: begin d.jump = 1; d.regwrite = 1; d.alusrc = 1; d.illegal = (f3 != 0); end
      'h37, 'h17: begin d.regwrite = 1; d.alusrc = 1; end
      default: d.illegal = 1;
    endcase
    if (d.illegal) begin
      d.alusrc = 0; d.regwrite = 0; d.memwrite = 0; d.memread = 0;
      d.branch = 0; d.jump = 0; d.aluop = 0;
    end
    return d;
  endfunction

  function automatic bit m_hazard();
    int op = int'(bus.instr[6:0]);
    bit u1 = !(op == 'h37 || op == 'h17 || op == 'h6f);
    bit u2 = (op == 'h33 || op == 'h23 || op == 'h63);
    return m_valid && m.memread && m.rd != 0 && bus.if_valid === 1'b1 &&
           ((u1 && int'(bus.instr[19:15]) == m.rd) || (u2 && int'(bus.instr[24:20]) == m.rd));
  endfunction

  function automatic bit m_ready();
    return (!m_valid || bus.ex_ready === 1'b1) && m_stall == 0 && !m_hazard() &&
           bus.flush !== 1'b1;
  endfunction

  function automatic int exp_ill();
    return IllEn ? m_ill : 0;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_stall = 0;
    m_ill   = 0;
  endtask

  task automatic model_step();
    bit rdy = m_ready();
    bit hz  = m_hazard();
    if (bus.flush === 1'b1) begin
      m_valid = 0;
      m_stall = 0;
    end else if (m_stall > 0) begin
      m_stall = m_stall - 1;
    end else if (bus.if_valid === 1'b1 && rdy) begin
      m       = ref_decode(bus.instr);
      m_valid = 1;
      if (m.illegal && m_ill < IllMax) m_ill = m_ill + 1;
    end else if (bus.ex_ready === 1'b1) begin
      m_valid = 0;
      if (hz) m_stall = BUBBLES - 1;
    end
  endtask

  task automatic compare_all();
    chk("ex_valid", bus.ex_valid, m_valid);
    chk("id_ready", bus.id_ready, m_ready());
    chk("ill_cnt", bus.ill_cnt, exp_ill());
    if (m_valid) begin
      chk("alusrc", bus.alusrc, m.alusrc);
      chk("regwrite", bus.regwrite, m.regwrite);
      chk("memwrite", bus.memwrite, m.memwrite);
      chk("memread", bus.memread, m.memread);
      chk("branch", bus.branch, m.branch);
      chk("jump", bus.jump, m.jump);
      chk("illegal", bus.illegal, m.illegal);
      chk("aluop", bus.aluop, m.aluop);
      chk("funct3_q", bus.funct3_q, m.f3);
      chk("rd_q", bus.rd_q, m.rd);
      chk("rs1_q", bus.rs1_q, m.rs1);
      chk("rs2_q", bus.rs2_q, m.rs2);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] w, input bit rdy, input bit fl);
    bus.if_valid = v;
    bus.instr    = w;
    bus.ex_ready = rdy;
    bus.flush    = fl;
  endtask

  task automatic sample();
    @(negedge clk);
    compare_all();
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd   = 5'($urandom_range(0, 3));
    logic [4:0]  rs1  = 5'($urandom_range(0, 3));
    logic [4:0]  rs2  = 5'($urandom_range(0, 3));
    logic [2:0]  f3   = 3'($urandom_range(0, 7));
    logic [6:0]  f7   = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
    logic [11:0] imm  = 12'($urandom);
    logic [31:0] w;
    case ($urandom_range(0, 10))
      0, 1: w = {f7, rs2, rs1, f3, rd, 7'h33};
      2:    w = {f7, rs2, rs1, f3, rd, 7'h13};
      3:    w = {imm, rs1, f3, rd, 7'h13};
      4, 5: w = {imm, rs1, ($urandom_range(0, 3) == 0) ? f3 : 3'd2, rd, 7'h03};
      6:    w = {imm[11:5], rs2, rs1, ($urandom_range(0, 3) == 0) ? f3 : 3'd2, imm[4:0], 7'h23};
      7:    w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h63};
      8:    w = {imm, rs1, ($urandom_range(0, 3) == 0) ? f3 : 3'd0, rd, 7'h67};
      9: begin
        w = $urandom;
        w[19:15] = rs1;
        case ($urandom_range(0, 2))
          0:       w[6:0] = 7'h6f;
          1:       w[6:0] = 7'h37;
          default: w[6:0] = 7'h17;
        endcase
      end
      default: w = $urandom;
    endcase
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 32'h0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state, with an add offered in the very first cycle.
    drive(1, AddX3, 1, 0);
    sample();
    chk("rst_ex_valid", bus.ex_valid, 0);
    chk("rst_regwrite", bus.regwrite, 0);
    chk("rst_aluop", bus.aluop, 0);
    chk("rst_rd_q", bus.rd_q, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_ill_cnt", bus.ill_cnt, 0);
    chk("first_id_ready", bus.id_ready, 1);
    advance();

    // Load-use: lw x5 then add x6,x5,x2.
    drive(1, LwX5, 1, 0);
    sample();
    chk("add_ex_valid", bus.ex_valid, 1);
    chk("add_regwrite", bus.regwrite, 1);
    chk("add_aluop", bus.aluop, 0);
    chk("add_rd_q", bus.rd_q, 3);
    advance();
    drive(1, AddX6, 1, 0);
    sample();
    chk("lu_memread", bus.memread, 1);
    chk("lu_hz_ready", bus.id_ready, 0);
    advance();
    sample();
    chk("lu_bubble1_valid", bus.ex_valid, 0);
    chk("lu_bubble1_ready", bus.id_ready, 0);
    advance();
    sample();
    chk("lu_bubble2_valid", bus.ex_valid, 0);
    chk("lu_bubble2_ready", bus.id_ready, 1);
    advance();
    drive(0, 32'h0, 1, 0);
    sample();
    chk("lu_emit_valid", bus.ex_valid, 1);
    chk("lu_emit_rd", bus.rd_q, 6);
    chk("lu_emit_rs1", bus.rs1_q, 5);
    advance();

    // Illegal words: two, then enough to saturate the counter.
    for (int i = 0; i < 303; i++) begin
      drive(i < 302, AllOne, 1, 0);
      sample();
      if (i == 2) begin
        chk("ill_flag", bus.illegal, 1);
        chk("ill_regwrite", bus.regwrite, 0);
        chk("ill_memread", bus.memread, 0);
        chk("ill_memwrite", bus.memwrite, 0);
        chk("ill_jump", bus.jump, 0);
        chk("ill_branch", bus.branch, 0);
        chk("ill_cnt_2", bus.ill_cnt, IllEn ? 2 : 0);
      end
      advance();
    end
    sample();
    chk("ill_cnt_sat", bus.ill_cnt, IllEn ? 255 : 0);
    advance();

    // Flush while stalled, with fetch still offering.
    drive(1, LwX5, 1, 0);
    sample();
    advance();
    drive(1, AddX6, 1, 0);
    sample();
    advance();
    drive(1, AddX6, 1, 1);
    sample();
    chk("fl_stall_ready", bus.id_ready, 0);
    advance();
    drive(1, AddX3, 1, 0);
    sample();
    chk("fl_valid", bus.ex_valid, 0);
    chk("fl_run_ready", bus.id_ready, 1);
    advance();
    drive(0, 32'h0, 0, 0);
    sample();
    chk("fl_next_valid", bus.ex_valid, 1);
    chk("fl_next_rd", bus.rd_q, 3);
    advance();

    // Hold under back-pressure, then asynchronous reset mid-hold.
    drive(1, SubX7, 1, 0);
    sample();
    advance();
    drive(1, AddX3, 0, 0);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("hold_valid", bus.ex_valid, 1);
      chk("hold_aluop", bus.aluop, 1);
      chk("hold_rd", bus.rd_q, 7);
      chk("hold_ready", bus.id_ready, 0);
      advance();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.ex_valid, 0);
    chk("arst_aluop", bus.aluop, 0);
    chk("arst_rd", bus.rd_q, 0);
    chk("arst_regwrite", bus.regwrite, 0);
    chk("arst_ill_cnt", bus.ill_cnt, 0);
    model_reset();
    drive(0, 32'h0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 80, rand_instr(), $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 5);
      sample();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
